// File: rtl/wave_pkg.sv
// Shared definitions for the waveform gain scaling stage.
//
// Contents:
//   GAIN_UNITY / GAIN_0P8 / GAIN_0P75 / GAIN_0P4 - unsigned Q1.15 gain constants
//   Q15_ROUND    - half-LSB offset added before the >>15 of a Q1.15 product
//   gain_state_t - encoding of the gain qualification state machine
package wave_pkg;

    localparam logic [15:0] GAIN_UNITY = 16'h8000;
    localparam logic [15:0] GAIN_0P8   = 16'h6666;
    localparam logic [15:0] GAIN_0P75  = 16'h6000;
    localparam logic [15:0] GAIN_0P4   = 16'h3333;

    localparam logic [15:0] Q15_ROUND  = 16'h4000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        PEND  = 2'd2
    } gain_state_t;

endpackage

// File: rtl/gain_lut.sv
// Combinational decode of the board waveform/gain selects into a Q1.15 gain.
//
// Ports:
//   code - {wave_sel, wave_gain}, each nominally one-hot
//   gain - unsigned Q1.15 gain; any unlisted code falls back to unity
module gain_lut
    import wave_pkg::*;
(
    input  logic [5:0]  code,
    output logic [15:0] gain
);

    always_comb begin
        gain = GAIN_UNITY;
        case (code)
            6'b001_001: gain = GAIN_UNITY;
            6'b010_001: gain = GAIN_0P8;
            6'b010_010: gain = GAIN_0P4;
            6'b100_001: gain = GAIN_0P8;
            6'b100_010: gain = GAIN_0P75;
            6'b100_100: gain = GAIN_0P4;
            default:    gain = GAIN_UNITY;
        endcase
    end

endmodule

// File: rtl/wave_gain_scaler.sv
// Pipelined amplitude scaler between flash_ctrl and flow_ctrl. Each incoming
// sample is multiplied by the currently applied Q1.15 gain, rounded half up
// and saturated. Gain changes arrive on asynchronous board selects, are
// synchronized, debounced for STABLE_CYC cycles and only applied while the
// pipeline is empty and no sample is arriving.
//
// Ports:
//   mclk, rst_n         - clock, asynchronous active-low reset
//   wave_sel, wave_gain - asynchronous one-hot selects from the board
//   in_dv, in_data      - raw unsigned sample strobe and data
//   out_dv, out_data    - scaled sample strobe; out_data holds between strobes
//   cur_gain            - gain currently applied to new samples (Q1.15)
//   gain_upd            - high in the cycle a qualified gain is loaded
//   busy                - any pipeline stage holds a valid sample
module wave_gain_scaler
    import wave_pkg::*;
#(
    parameter int DATA_NBIT  = 20,
    parameter int STABLE_CYC = 4
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic [2:0]           wave_sel,
    input  logic [2:0]           wave_gain,
    input  logic                 in_dv,
    input  logic [DATA_NBIT-1:0] in_data,
    output logic                 out_dv,
    output logic [DATA_NBIT-1:0] out_data,
    output logic [15:0]          cur_gain,
    output logic                 gain_upd,
    output logic                 busy
);

    localparam int PROD_W = DATA_NBIT + 16;
    localparam int SUM_W  = DATA_NBIT + 17;
    localparam int RES_W  = DATA_NBIT + 2;
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYC - 1);

    logic [5:0]            sync_meta;
    logic [5:0]            sync_code;
    logic [15:0]           dec_gain;

    gain_state_t           state;
    gain_state_t           next_state;
    logic [15:0]           cand;
    logic [15:0]           next_cand;
    logic [7:0]            cnt;
    logic [7:0]            next_cnt;
    logic                  take_update;

    logic                  v1;
    logic                  v2;
    logic [DATA_NBIT-1:0]  s1_data;
    logic [15:0]           s1_gain;
    logic [PROD_W-1:0]     s2_prod;
    logic [RES_W-1:0]      rnd_res;

    // Two-flop synchronizer for the board selects; both halves of the code
    // move together so the decoder never sees a mixed old/new pair for long.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_code <= '0;
        end else begin
            sync_meta <= {wave_sel, wave_gain};
            sync_code <= sync_meta;
        end
    end

    gain_lut u_gain_lut (
        .code (sync_code),
        .gain (dec_gain)
    );

    // Gain qualification state register; cur_gain is only ever loaded from a
    // fully debounced candidate.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cand     <= GAIN_UNITY;
            cnt      <= '0;
            cur_gain <= GAIN_UNITY;
        end else begin
            state <= next_state;
            cand  <= next_cand;
            cnt   <= next_cnt;
            if (take_update) begin
                cur_gain <= cand;
            end
        end
    end

    // Next-state logic. A decoded value that changes while counting or
    // pending restarts qualification; in PEND a change takes priority over
    // applying the stale candidate.
    always_comb begin
        next_state  = state;
        next_cand   = cand;
        next_cnt    = cnt;
        take_update = 1'b0;
        case (state)
            IDLE: begin
                if (dec_gain != cur_gain) begin
                    next_cand  = dec_gain;
                    next_cnt   = '0;
                    next_state = COUNT;
                end
            end
            COUNT: begin
                if (dec_gain != cand) begin
                    next_cand = dec_gain;
                    next_cnt  = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = (cand == cur_gain) ? IDLE : PEND;
                end else begin
                    next_cnt = cnt + 8'd1;
                end
            end
            PEND: begin
                if (dec_gain != cand) begin
                    next_cand  = dec_gain;
                    next_cnt   = '0;
                    next_state = COUNT;
                end else if (!in_dv && !busy) begin
                    take_update = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign gain_upd = take_update;

    // Stage 1: capture the sample together with the gain in force when it
    // arrived, so later gain loads cannot affect it.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            s1_data <= '0;
            s1_gain <= GAIN_UNITY;
        end else begin
            v1 <= in_dv;
            if (in_dv) begin
                s1_data <= in_data;
                s1_gain <= cur_gain;
            end
        end
    end

    // Stage 2: full-width unsigned product.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            s2_prod <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                s2_prod <= PROD_W'(s1_data) * PROD_W'(s1_gain);
            end
        end
    end

    // Round half up and drop the 15 fractional bits; two extra integer bits
    // are kept so an overflow can be detected.
    assign rnd_res = RES_W'((SUM_W'(s2_prod) + SUM_W'(Q15_ROUND)) >> 15);

    // Stage 3: saturate to the sample width; out_data holds between strobes.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            out_dv   <= 1'b0;
            out_data <= '0;
        end else begin
            out_dv <= v2;
            if (v2) begin
                if (|rnd_res[RES_W-1:DATA_NBIT]) begin
                    out_data <= '1;
                end else begin
                    out_data <= rnd_res[DATA_NBIT-1:0];
                end
            end
        end
    end

    assign busy = v1 | v2 | out_dv;

endmodule

// File: tb/tb_wave_gain_scaler.sv
// Self-checking bench for wave_gain_scaler: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural model.
module tb_wave_gain_scaler;

    localparam int DATA_NBIT  = 20;
    localparam int STABLE_CYC = 4;
    localparam logic [19:0] MAXV = 20'hFFFFF;

    logic        mclk = 1'b0;
    logic        rst_n;
    logic [2:0]  wave_sel;
    logic [2:0]  wave_gain;
    logic        in_dv;
    logic [19:0] in_data;
    logic        out_dv;
    logic [19:0] out_data;
    logic [15:0] cur_gain;
    logic        gain_upd;
    logic        busy;

    always #5 mclk = ~mclk;

    wave_gain_scaler #(
        .DATA_NBIT  (DATA_NBIT),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .wave_sel  (wave_sel),
        .wave_gain (wave_gain),
        .in_dv     (in_dv),
        .in_data   (in_data),
        .out_dv    (out_dv),
        .out_data  (out_data),
        .cur_gain  (cur_gain),
        .gain_upd  (gain_upd),
        .busy      (busy)
    );

    int compareCount  = 0;
    int mismatchCount = 0;

    // Model state: applied gain, codes seen one and two cycles ago (the
    // board-to-core delay), run length of the current decoded gain, and a
    // queue of expected outputs keyed by the cycle they are due.
    typedef struct {
        int          due;
        logic [19:0] val;
    } exp_t;

    exp_t        expQ[$];
    logic [15:0] modelGain;
    logic [5:0]  codeD1;
    logic [5:0]  codeD2;
    logic [15:0] prevDec;
    int          runLen;
    logic [19:0] lastOut;
    int          cycle = 0;

    function automatic logic [15:0] refGain(input logic [5:0] code);
        case (code)
            6'b001001: return 16'h8000;
            6'b010001: return 16'h6666;
            6'b010010: return 16'h3333;
            6'b100001: return 16'h6666;
            6'b100010: return 16'h6000;
            6'b100100: return 16'h3333;
            default:   return 16'h8000;
        endcase
    endfunction

    function automatic logic [19:0] refScale(input logic [19:0] d, input logic [15:0] g);
        longint r;
        r = (longint'(d) * longint'(g) + 64'd16384) / 64'd32768;
        if (r > longint'(MAXV)) return MAXV;
        return r[19:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    task automatic modelReset();
        expQ.delete();
        modelGain = 16'h8000;
        codeD2    = 6'b0;
        codeD1    = {wave_sel, wave_gain};
        prevDec   = 16'h8000;
        runLen    = 1;
        lastOut   = 20'h0;
    endtask

    // One clock cycle: drive inputs mid-cycle, compare every output with the
    // model, then advance the model past the next rising edge.
    task automatic applyStimulus(input bit dv, input logic [19:0] data, input logic [2:0] sel, input logic [2:0] gsel);
        logic [15:0] decNow;
        bit          busyNow;
        bit          emitNow;
        bit          updNow;
        @(negedge mclk);
        in_dv     = dv;
        in_data   = data;
        wave_sel  = sel;
        wave_gain = gsel;
        #1;
        decNow = refGain(codeD2);
        if (decNow == prevDec) runLen++;
        else runLen = 1;
        prevDec = decNow;
        busyNow = (expQ.size() != 0);
        emitNow = busyNow && (expQ[0].due == cycle);
        if (emitNow) lastOut = expQ[0].val;
        updNow = (runLen >= STABLE_CYC + 2) && (decNow != modelGain) && !dv && !busyNow;
        checkOutput("out_dv",   {31'b0, out_dv},   {31'b0, emitNow});
        checkOutput("out_data", {12'b0, out_data}, {12'b0, lastOut});
        checkOutput("busy",     {31'b0, busy},     {31'b0, busyNow});
        checkOutput("cur_gain", {16'b0, cur_gain}, {16'b0, modelGain});
        checkOutput("gain_upd", {31'b0, gain_upd}, {31'b0, updNow});
        if (emitNow) void'(expQ.pop_front());
        if (dv) expQ.push_back('{due: cycle + 3, val: refScale(data, modelGain)});
        if (updNow) modelGain = decNow;
        codeD2 = codeD1;
        codeD1 = {sel, gsel};
        cycle++;
    endtask

    task automatic idleCycles(input int n, input logic [2:0] sel, input logic [2:0] gsel);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 20'h0, sel, gsel);
    endtask

    // Asynchronous reset between clock edges; outputs must clear immediately.
    task automatic applyReset();
        @(negedge mclk);
        #2;
        rst_n = 1'b0;
        in_dv = 1'b0;
        #1;
        checkOutput("rst_out_dv",   {31'b0, out_dv},   32'h0);
        checkOutput("rst_out_data", {12'b0, out_data}, 32'h0);
        checkOutput("rst_gain_upd", {31'b0, gain_upd}, 32'h0);
        checkOutput("rst_busy",     {31'b0, busy},     32'h0);
        checkOutput("rst_cur_gain", {16'b0, cur_gain}, 32'h8000);
        repeat (2) @(negedge mclk);
        rst_n = 1'b1;
        modelReset();
    endtask

    logic [5:0] codeTable [8] = '{6'b001001, 6'b010001, 6'b010010, 6'b100001,
                                  6'b100010, 6'b100100, 6'b000000, 6'b111011};

    initial begin
        logic [5:0]  code;
        int          holdLeft;
        logic [19:0] d;
        rst_n     = 1'b0;
        in_dv     = 1'b0;
        in_data   = '0;
        wave_sel  = 3'b001;
        wave_gain = 3'b001;
        applyReset();

        // Unity gain passthrough of extreme values.
        applyStimulus(1'b1, 20'hFFFFF, 3'b001, 3'b001);
        applyStimulus(1'b1, 20'h00001, 3'b001, 3'b001);
        applyStimulus(1'b1, 20'h80000, 3'b001, 3'b001);
        idleCycles(4, 3'b001, 3'b001);

        // 0.8 gain: 0x80000 scales to 0x66660.
        idleCycles(STABLE_CYC + 8, 3'b010, 3'b001);
        applyStimulus(1'b1, 20'h80000, 3'b010, 3'b001);
        idleCycles(4, 3'b010, 3'b001);
        checkOutput("scale_0p8", {12'b0, out_data}, 32'h66660);

        // Rounding with 0.75 and 0.4 gains.
        idleCycles(STABLE_CYC + 8, 3'b100, 3'b010);
        applyStimulus(1'b1, 20'd1, 3'b100, 3'b010);
        idleCycles(4, 3'b100, 3'b010);
        checkOutput("round_0p75", {12'b0, out_data}, 32'd1);
        idleCycles(STABLE_CYC + 8, 3'b010, 3'b010);
        applyStimulus(1'b1, 20'd3, 3'b010, 3'b010);
        idleCycles(3, 3'b010, 3'b010);
        checkOutput("round_3", {12'b0, out_data}, 32'd1);
        applyStimulus(1'b1, 20'd5, 3'b010, 3'b010);
        idleCycles(3, 3'b010, 3'b010);
        checkOutput("round_5", {12'b0, out_data}, 32'd2);

        // Debounce: glitches of length around the qualification threshold.
        for (int len = STABLE_CYC - 1; len <= STABLE_CYC + 2; len++) begin
            idleCycles(len, 3'b001, 3'b001);
            idleCycles(STABLE_CYC + 6, 3'b010, 3'b010);
        end
        idleCycles(STABLE_CYC + 8, 3'b100, 3'b001);

        // Deferred update under continuous traffic.
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 20'($urandom), 3'b100, 3'b100);
        idleCycles(10, 3'b100, 3'b100);

        // Reset with samples in flight and a new code on the board.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 20'($urandom), 3'b100, 3'b010);
        applyReset();
        idleCycles(STABLE_CYC + 8, 3'b100, 3'b010);

        // Randomized traffic with random code holds and occasional resets.
        code     = codeTable[0];
        holdLeft = 0;
        for (int i = 0; i < 1500; i++) begin
            if (holdLeft == 0) begin
                code     = ($urandom_range(0, 9) == 0) ? 6'($urandom) : codeTable[$urandom_range(0, 7)];
                holdLeft = $urandom_range(1, 14);
            end
            holdLeft--;
            case ($urandom_range(0, 3))
                0:       d = MAXV;
                1:       d = 20'($urandom_range(0, 7));
                default: d = 20'($urandom);
            endcase
            applyStimulus($urandom_range(0, 2) == 0, d, code[5:3], code[2:0]);
            if ($urandom_range(0, 499) == 0) applyReset();
        end
        idleCycles(6, code[5:3], code[2:0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
